// File: rtl/dffram_port_arbiter.sv
// dffram_port_arbiter: shares one byte-writable DFFRAM between a fetch port and a load/store port
module dffram_port_arbiter #(
  parameter int ADDRESS_LENGTH = 11,
  parameter int DATA_LENGTH    = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_req,
  input  logic [ADDRESS_LENGTH-1:0] i_addr,
  output logic                      i_gnt,
  output logic                      i_rvalid,
  output logic [DATA_LENGTH-1:0]    i_rdata,
  input  logic                      d_req,
  input  logic [ADDRESS_LENGTH-1:0] d_addr,
  input  logic [3:0]                d_we,
  input  logic [DATA_LENGTH-1:0]    d_wdata,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [DATA_LENGTH-1:0]    d_rdata,
  output logic                      ram_EN,
  output logic [3:0]                ram_WE,
  output logic [ADDRESS_LENGTH-1:0] ram_A,
  output logic [DATA_LENGTH-1:0]    ram_Di,
  input  logic [DATA_LENGTH-1:0]    ram_Do,
  output logic                      busy
);
  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
  state_t                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic [ADDRESS_LENGTH-1:0] addr_q, addr_d;
  logic [3:0]                we_q, we_d;
  logic [DATA_LENGTH-1:0]    wdata_q, wdata_d;
  logic                      win, gnt, mem_act, resp_act;
  // owner_q: 1 = data port; it is both the current owner and the round-robin history
  always_comb begin
    win      = (state_q != MEM) && !RST;
    i_gnt    = win && i_req && (!d_req || owner_q);
    d_gnt    = win && d_req && (!i_req || !owner_q);
    gnt      = i_gnt || d_gnt;
    state_d  = gnt ? MEM : (state_q == MEM) ? RESP : IDLE;
    owner_d  = gnt ? d_gnt : owner_q;
    addr_d   = d_gnt ? d_addr : i_gnt ? i_addr : addr_q;
    we_d     = d_gnt ? d_we : i_gnt ? 4'b0000 : we_q;
    wdata_d  = d_gnt ? d_wdata : i_gnt ? '0 : wdata_q;
    mem_act  = (state_q == MEM) && !RST;
    resp_act = (state_q == RESP) && !RST;
    ram_EN   = mem_act;
    ram_WE   = mem_act ? we_q : 4'b0000;
    ram_A    = mem_act ? addr_q : '0;
    ram_Di   = mem_act ? wdata_q : '0;
    i_rvalid = resp_act && !owner_q;
    d_rvalid = resp_act && owner_q;
    i_rdata  = i_rvalid ? ram_Do : '0;
    d_rdata  = d_rvalid ? ram_Do : '0;
    busy     = state_q != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      addr_q  <= '0;
      we_q    <= 4'b0000;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_dffram_port_arbiter.sv
// tb_dffram_port_arbiter: directed scoreboard bench with a behavioural registered-read RAM
module tb_dffram_port_arbiter;
  logic        CLK = 0, RST = 1;
  logic        i_req = 0, d_req = 0;
  logic [10:0] i_addr = 0, d_addr = 0;
  logic [3:0]  d_we = 0;
  logic [31:0] d_wdata = 0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, ram_EN, busy;
  logic [31:0] i_rdata, d_rdata, ram_Di, ram_Do;
  logic [3:0]  ram_WE;
  logic [10:0] ram_A;
  typedef struct {logic port; logic [31:0] data; int cyc;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, en_cnt = 0;
  logic [31:0] mem [2048];

  dffram_port_arbiter dut (
    .CLK(CLK), .RST(RST),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_EN(ram_EN), .ram_WE(ram_WE), .ram_A(ram_A), .ram_Di(ram_Di), .ram_Do(ram_Do),
    .busy(busy)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // RAM macro model: registered read of old contents, byte-lane writes, Do zero when EN low
  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    mem[1]  = 32'h01010101;
    mem[2]  = 32'h02020202;
    mem[5]  = 32'hDEADBEEF;
    mem[7]  = 32'h77777777;
    mem[10] = 32'h11111111;
    mem[20] = 32'h22222222;
    ram_Do = 0;
    forever begin
      @(posedge CLK);
      if (ram_EN) begin
        ram_Do <= mem[ram_A];
        for (int b = 0; b < 4; b++)
          if (ram_WE[b]) mem[ram_A][8*b +: 8] <= ram_Di[8*b +: 8];
      end else ram_Do <= 32'h0;
    end
  end

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", n, act, exp, cyc);
    end
  endfunction

  always @(negedge CLK) begin
    if (ram_EN) en_cnt++;
    if (i_rvalid && d_rvalid) chk("both_rvalid", 1, 0);
    if (!i_rvalid && i_rdata !== 0) chk("i_rdata_idle", i_rdata, 0);
    if (!d_rvalid && d_rdata !== 0) chk("d_rdata_idle", d_rdata, 0);
    if (i_rvalid || d_rvalid) begin
      if (q.size() == 0) chk("unexpected_rvalid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rvalid_port", {31'b0, d_rvalid}, {31'b0, e.port});
        chk("rdata", d_rvalid ? d_rdata : i_rdata, e.data);
        chk("rvalid_cycle", cyc, e.cyc);
      end
    end
  end

  // Called just after a posedge; returns just after the posedge that starts the response cycle
  task automatic access(input logic port, input logic [10:0] a, input logic [3:0] we,
                        input logic [31:0] wd, input logic [31:0] exp, output int gcyc);
    bit got = 0;
    if (port) begin d_addr = a; d_we = we; d_wdata = wd; d_req = 1; end
    else begin i_addr = a; i_req = 1; end
    gcyc = -1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge CLK);
      if (port ? d_gnt : i_gnt) got = 1;
      else begin @(posedge CLK); #1; end
    end
    if (!got) begin
      chk("gnt_timeout", 0, 1);
      i_req = 0; d_req = 0;
      return;
    end
    chk("en_in_gnt_cycle", {31'b0, ram_EN}, 0);
    gcyc = cyc;
    q.push_back('{port, exp, cyc + 2});
    @(posedge CLK); #1;
    if (port) d_req = 0; else i_req = 0;
    @(negedge CLK);
    chk("mem_en", {31'b0, ram_EN}, 1);
    chk("mem_addr", {21'b0, ram_A}, {21'b0, a});
    chk("mem_we", {28'b0, ram_WE}, {28'b0, port ? we : 4'b0});
    if (we != 0) chk("mem_di", ram_Di, wd);
    @(posedge CLK); #1;
  endtask

  initial begin
    int g1, g2, g3, e0;
    logic ep;
    repeat (3) @(posedge CLK);
    #1 d_req = 1;
    @(negedge CLK);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_outs", {31'b0, |{i_gnt, d_gnt, i_rvalid, d_rvalid, ram_EN, ram_WE, ram_A, ram_Di, i_rdata, d_rdata}}, 0);
    @(posedge CLK); #1;
    RST = 0; d_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("idle_quiet", {30'b0, busy, ram_EN}, 0);
    end
    @(posedge CLK); #1;
    access(0, 11'd5, 4'b0, 32'h0, 32'hDEADBEEF, g1);
    access(1, 11'd3, 4'b0101, 32'hAABBCCDD, 32'h0, g1);
    access(1, 11'd3, 4'b0, 32'h0, 32'h00BB00DD, g1);
    e0 = en_cnt;
    access(1, 11'd1, 4'b0, 32'h0, 32'h01010101, g1);
    access(1, 11'd2, 4'b0, 32'h0, 32'h02020202, g2);
    access(1, 11'd3, 4'b0, 32'h0, 32'h00BB00DD, g3);
    chk("b2b_gap1", g2 - g1, 2);
    chk("b2b_gap2", g3 - g2, 2);
    repeat (3) @(posedge CLK);
    chk("b2b_en_count", en_cnt - e0, 3);
    #1 RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    i_addr = 11'd10; d_addr = 11'd20; d_we = 0; i_req = 1; d_req = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      chk("tie_one_gnt", {31'b0, i_gnt && d_gnt}, 0);
      if (c % 2 == 0) begin
        ep = ((c / 2) % 2) == 1;
        chk("tie_i_gnt", {31'b0, i_gnt}, {31'b0, !ep});
        chk("tie_d_gnt", {31'b0, d_gnt}, {31'b0, ep});
      end else chk("tie_no_gnt", {30'b0, i_gnt, d_gnt}, 0);
      if (i_gnt) q.push_back('{1'b0, 32'h11111111, cyc + 2});
      if (d_gnt) q.push_back('{1'b1, 32'h22222222, cyc + 2});
      @(posedge CLK); #1;
    end
    i_req = 0; d_req = 0;
    repeat (3) @(posedge CLK);
    #1 d_addr = 11'd7; d_we = 4'hF; d_wdata = 32'hCAFEF00D; d_req = 1;
    @(negedge CLK);
    chk("wr_gnt", {31'b0, d_gnt}, 1);
    @(posedge CLK); #1;
    d_req = 0; RST = 1;
    @(negedge CLK);
    chk("rst_mem_we", {28'b0, ram_WE}, 0);
    chk("rst_mem_en", {31'b0, ram_EN}, 0);
    @(posedge CLK); #1;
    RST = 0; d_we = 0;
    @(negedge CLK);
    chk("post_rst_outs", {31'b0, |{busy, i_gnt, d_gnt, i_rvalid, d_rvalid, ram_EN, ram_WE, ram_A, ram_Di, i_rdata, d_rdata}}, 0);
    @(posedge CLK); #1;
    access(1, 11'd7, 4'b0, 32'h0, 32'h77777777, g1);
    repeat (3) @(posedge CLK);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
